// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
// Contents:
//   - opcode constants for the supported instruction subset
//   - FSM state enum (4-bit binary)
//   - encodings for the ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc selects
// Optional build macro ITYPE_ALU_EN enables the ST_EXECUTEI path in the top.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BEQ      = 4'd8,
    ST_EXECUTEI = 4'd9
  } state_e;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/mcu_imm_src_dec.sv
// Combinational opcode -> immediate-format decode.
// Shared with the single-cycle core, so it depends only on the opcode.
// Ports:
//   op      : instruction opcode field
//   imm_src : immediate format select (00=I, 01=S, 10=B)
module mcu_imm_src_dec
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle RISC-V datapath (lw, sw, R-type, beq).
// Sequences the shared memory and ALU, stalls on mem_ready and counts retired
// instructions. Optional macro ITYPE_ALU_EN adds the I-type ALU path
// (opcode 0010011 via ST_EXECUTEI); without it that opcode is illegal.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   op, zero          : opcode field, ALU zero flag
//   mem_ready         : memory access completes this cycle
//   PCWrite .. ImmSrc : datapath enables and mux selects
//   RegWrite          : register file write strobe
//   illegal_op        : one-cycle pulse on an unsupported opcode in DECODE
//   instret           : retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic pc_update, branch, retire;
  logic ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

  mcu_imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (ImmSrc)
  );

  always_comb begin
    state_d       = state_q;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    ALUOp         = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        // IR and PC only latch on the cycle the fetch actually completes.
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_update    = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target PC+imm is parked in ALUOut for a possible beq.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECUTER;
          OP_BEQ:       state_d = ST_BEQ;
`ifdef ITYPE_ALU_EN
          OP_ITYPE:     state_d = ST_EXECUTEI;
`endif
          default: begin
            illegal_raw = 1'b1;
            state_d     = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
      end
      ST_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEMWRITE: begin
        // The store strobe is held for the whole stall; it retires on ready.
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        ALUOp   = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
`ifdef ITYPE_ALU_EN
      ST_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
`endif
      ST_ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are masked while reset is held: FETCH would otherwise raise
  // IRWrite/PCWrite whenever mem_ready happens to be high.
  assign PCWrite    = rst_n & (pc_update | (branch & zero));
  assign IRWrite    = rst_n & ir_write_raw;
  assign MemWrite   = rst_n & mem_write_raw;
  assign RegWrite   = rst_n & reg_write_raw;
  assign illegal_op = rst_n & illegal_raw;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] instret;

  multicycle_control_unit #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,illegal_op}
  logic [13:0] sig;
  assign sig = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUOp, RegWrite, illegal_op};

  localparam logic [13:0] S_FETCH   = 14'b1_0_0_1_10_00_10_00_0_0;
  localparam logic [13:0] S_FSTALL  = 14'b0_0_0_0_10_00_10_00_0_0;
  localparam logic [13:0] S_DEC     = 14'b0_0_0_0_00_01_01_00_0_0;
  localparam logic [13:0] S_DEC_ILL = 14'b0_0_0_0_00_01_01_00_0_1;
  localparam logic [13:0] S_MADR    = 14'b0_0_0_0_00_10_01_00_0_0;
  localparam logic [13:0] S_MRD     = 14'b0_1_0_0_00_00_00_00_0_0;
  localparam logic [13:0] S_MWB     = 14'b0_0_0_0_01_00_00_00_1_0;
  localparam logic [13:0] S_MWR     = 14'b0_1_1_0_00_00_00_00_0_0;
  localparam logic [13:0] S_EXR     = 14'b0_0_0_0_00_10_00_10_0_0;
  localparam logic [13:0] S_EXI     = 14'b0_0_0_0_00_10_01_10_0_0;
  localparam logic [13:0] S_AWB     = 14'b0_0_0_0_00_00_00_00_1_0;
  localparam logic [13:0] S_BEQT    = 14'b1_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] S_BEQN    = 14'b0_0_0_0_00_10_00_01_0_0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, IT = 7'b0010011, BAD = 7'b1111111;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_cnt;

  // Inputs change and outputs are sampled 1-2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = LW; mem_ready = 1'b1; zero = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    tick(); tick(); tick();   // FETCH -> DECODE -> MEMADR -> MEMREAD
    #1;
    n_cmp++;
    if (sig !== S_MRD) begin n_bad++; $display("FAIL rst_pre_memread got=%b exp=%b", sig, S_MRD); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sig !== S_FSTALL) begin n_bad++; $display("FAIL rst_async_ctrl got=%b exp=%b", sig, S_FSTALL); end
    n_cmp++;
    if (instret !== 4'd0) begin n_bad++; $display("FAIL rst_instret got=%0d exp=0", instret); end
    tick();
    n_cmp++;
    if (sig !== S_FSTALL) begin n_bad++; $display("FAIL rst_held_ctrl got=%b exp=%b", sig, S_FSTALL); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (sig !== S_FETCH) begin n_bad++; $display("FAIL rst_release_fetch got=%b exp=%b", sig, S_FETCH); end
  endtask

  task automatic test_lw();
    logic [13:0] es [6];
    logic        rt [6];
    es = '{S_FETCH, S_DEC, S_MADR, S_MRD, S_MWB, S_FETCH};
    rt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = LW; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (sig !== es[i]) begin n_bad++; $display("FAIL lw_ctrl[%0d] got=%b exp=%b", i, sig, es[i]); end
      n_cmp++;
      if (instret !== exp_cnt) begin n_bad++; $display("FAIL lw_instret[%0d] got=%0d exp=%0d", i, instret, exp_cnt); end
      if (i < 5) begin tick(); if (rt[i]) exp_cnt++; end
    end
    n_cmp++;
    if (ImmSrc !== 2'b00) begin n_bad++; $display("FAIL lw_immsrc got=%b exp=00", ImmSrc); end
  endtask

  task automatic test_sw_stall();
    logic [13:0] es [8];
    logic        mr [8];
    logic [6:0]  ops [8];
    logic [1:0]  im [8];
    logic        rt [8];
    es  = '{S_FETCH, S_DEC, S_MADR, S_MWR, S_MWR, S_MWR, S_MWR, S_FETCH};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ops = '{SW, SW, SW, BAD, BAD, SW, SW, SW};
    im  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    rt  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; op = ops[i];
      #1;
      n_cmp++;
      if (sig !== es[i]) begin n_bad++; $display("FAIL sw_ctrl[%0d] got=%b exp=%b", i, sig, es[i]); end
      n_cmp++;
      if (ImmSrc !== im[i]) begin n_bad++; $display("FAIL sw_immsrc[%0d] got=%b exp=%b", i, ImmSrc, im[i]); end
      n_cmp++;
      if (instret !== exp_cnt) begin n_bad++; $display("FAIL sw_instret[%0d] got=%0d exp=%0d", i, instret, exp_cnt); end
      if (i < 7) begin tick(); if (rt[i]) exp_cnt++; end
    end
  endtask

  task automatic test_rtype_fetch_stall();
    logic [13:0] es [8];
    logic        mr [8];
    logic        rt [8];
    es = '{S_FSTALL, S_FSTALL, S_FSTALL, S_FETCH, S_DEC, S_EXR, S_AWB, S_FETCH};
    mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = RT;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      n_cmp++;
      if (sig !== es[i]) begin n_bad++; $display("FAIL rtype_ctrl[%0d] got=%b exp=%b", i, sig, es[i]); end
      n_cmp++;
      if (instret !== exp_cnt) begin n_bad++; $display("FAIL rtype_instret[%0d] got=%0d exp=%0d", i, instret, exp_cnt); end
      if (i < 7) begin tick(); if (rt[i]) exp_cnt++; end
    end
  endtask

  task automatic test_beq();
    logic [13:0] es [4];
    for (int z = 1; z >= 0; z--) begin
      es = '{S_FETCH, S_DEC, (z == 1) ? S_BEQT : S_BEQN, S_FETCH};
      op = BQ; mem_ready = 1'b1; zero = (z == 1);
      for (int i = 0; i < 4; i++) begin
        #1;
        n_cmp++;
        if (sig !== es[i]) begin n_bad++; $display("FAIL beq_z%0d_ctrl[%0d] got=%b exp=%b", z, i, sig, es[i]); end
        n_cmp++;
        if (instret !== exp_cnt) begin n_bad++; $display("FAIL beq_z%0d_instret[%0d] got=%0d exp=%0d", z, i, instret, exp_cnt); end
        if (i < 3) begin tick(); if (i == 2) exp_cnt++; end
      end
      n_cmp++;
      if (ImmSrc !== 2'b10) begin n_bad++; $display("FAIL beq_immsrc got=%b exp=10", ImmSrc); end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [13:0] es [3];
    es = '{S_FETCH, S_DEC_ILL, S_FETCH};
    op = BAD; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (sig !== es[i]) begin n_bad++; $display("FAIL illegal_ctrl[%0d] got=%b exp=%b", i, sig, es[i]); end
      n_cmp++;
      if (instret !== exp_cnt) begin n_bad++; $display("FAIL illegal_instret[%0d] got=%0d exp=%0d", i, instret, exp_cnt); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_itype();
`ifdef ITYPE_ALU_EN
    logic [13:0] es [5];
    logic        rt [5];
    es = '{S_FETCH, S_DEC, S_EXI, S_AWB, S_FETCH};
    rt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    logic [13:0] es [5];
    logic        rt [5];
    es = '{S_FETCH, S_DEC_ILL, S_FETCH, S_DEC_ILL, S_FETCH};
    rt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    op = IT; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (sig !== es[i]) begin n_bad++; $display("FAIL itype_ctrl[%0d] got=%b exp=%b", i, sig, es[i]); end
      n_cmp++;
      if (instret !== exp_cnt) begin n_bad++; $display("FAIL itype_instret[%0d] got=%0d exp=%0d", i, instret, exp_cnt); end
      if (i < 4) begin tick(); if (rt[i]) exp_cnt++; end
    end
    n_cmp++;
    if (ImmSrc !== 2'b00) begin n_bad++; $display("FAIL itype_immsrc got=%b exp=00", ImmSrc); end
  endtask

  task automatic test_wrap();
    // Abandon a counted history mid-lw: reset must clear instret.
    op = LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instret !== 4'd0) begin n_bad++; $display("FAIL wrap_reset_instret got=%0d exp=0", instret); end
    tick();
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    op = RT;
    for (int k = 0; k < 16; k++) begin
      repeat (4) tick();
      exp_cnt++;
      if (k == 14) begin
        n_cmp++;
        if (instret !== 4'hF) begin n_bad++; $display("FAIL wrap_allones got=%0d exp=15", instret); end
      end
      if (k == 15) begin
        n_cmp++;
        if (instret !== 4'h0) begin n_bad++; $display("FAIL wrap_zero got=%0d exp=0", instret); end
      end
    end
    n_cmp++;
    if (sig !== S_FETCH) begin n_bad++; $display("FAIL wrap_end_ctrl got=%b exp=%b", sig, S_FETCH); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_fetch_stall();
    test_beq();
    test_illegal();
    test_itype();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
